// File: rtl/confreg_sram_slave.sv
// Configuration/peripheral register block on the data SRAM port: LEDs, display,
// synchronized switches and a compare timer whose interrupt feeds the CPU ext_int.
module confreg_sram_slave #(
    parameter logic [15:0] BASE_HI = 16'h1faf,
    parameter int unsigned SW_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [3:0]      wen,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [SW_W-1:0] switch_i,
    output logic [15:0]     led_o,
    output logic [1:0]      led_rg0_o,
    output logic [1:0]      led_rg1_o,
    output logic [31:0]     num_o,
    output logic            timer_int_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 16;
    localparam int unsigned LED_W  = 16;
    localparam int unsigned RG_W   = 2;

    localparam logic [OFF_W-1:0] OFF_LED    = 16'hF000;
    localparam logic [OFF_W-1:0] OFF_RG0    = 16'hF004;
    localparam logic [OFF_W-1:0] OFF_RG1    = 16'hF008;
    localparam logic [OFF_W-1:0] OFF_NUM    = 16'hF010;
    localparam logic [OFF_W-1:0] OFF_SWITCH = 16'hF020;
    localparam logic [OFF_W-1:0] OFF_TIMER  = 16'hE000;
    localparam logic [OFF_W-1:0] OFF_CMP    = 16'hE004;
    localparam logic [OFF_W-1:0] OFF_CTRL   = 16'hE008;
    localparam logic [OFF_W-1:0] WORD_MASK  = 16'hFFFC;

    logic [DATA_W-1:0] r_rdata;
    logic [LED_W-1:0]  r_led;
    logic [RG_W-1:0]   r_rg0;
    logic [RG_W-1:0]   r_rg1;
    logic [DATA_W-1:0] r_num;
    logic [DATA_W-1:0] r_timer;
    logic [DATA_W-1:0] r_cmp;
    logic              r_ctrl_en;
    logic              r_ctrl_ie;
    logic              r_ctrl_pend;
    logic [SW_W-1:0]   r_sw_s1;
    logic [SW_W-1:0]   r_sw_s2;

    logic              w_hit;
    logic              w_wr;
    logic              w_rd;
    logic [OFF_W-1:0]  w_off;
    logic              w_sel_led;
    logic              w_sel_rg0;
    logic              w_sel_rg1;
    logic              w_sel_num;
    logic              w_sel_timer;
    logic              w_sel_cmp;
    logic              w_sel_ctrl;
    logic [DATA_W-1:0] w_rd_mux;
    logic [DATA_W-1:0] w_timer_wr;
    logic [DATA_W-1:0] w_cmp_wr;
    logic [DATA_W-1:0] w_num_wr;
    logic              w_cmp_match;
    logic              w_ctrl_wr;
    logic              w_pend_clr;

    // Per-lane merge: lanes without a write enable keep the old value.
    function automatic logic [DATA_W-1:0] f_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [3:0]        be
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    // Address decode; the two byte-offset bits are masked off.
    assign w_off       = addr[15:0] & WORD_MASK;
    assign w_hit       = en && (addr[31:16] == BASE_HI);
    assign w_wr        = w_hit && (wen != 4'b0000);
    assign w_rd        = en && (wen == 4'b0000);
    assign w_sel_led   = (w_off == OFF_LED);
    assign w_sel_rg0   = (w_off == OFF_RG0);
    assign w_sel_rg1   = (w_off == OFF_RG1);
    assign w_sel_num   = (w_off == OFF_NUM);
    assign w_sel_timer = (w_off == OFF_TIMER);
    assign w_sel_cmp   = (w_off == OFF_CMP);
    assign w_sel_ctrl  = (w_off == OFF_CTRL);

    assign w_timer_wr  = f_merge(r_timer, wdata, wen);
    assign w_cmp_wr    = f_merge(r_cmp, wdata, wen);
    assign w_num_wr    = f_merge(r_num, wdata, wen);
    assign w_ctrl_wr   = w_wr && w_sel_ctrl && wen[0];
    assign w_pend_clr  = w_ctrl_wr && wdata[2];
    assign w_cmp_match = r_ctrl_en && (r_timer == r_cmp);

    always_comb begin
        w_rd_mux = '0;
        case (w_off)
            OFF_LED:    w_rd_mux = DATA_W'(r_led);
            OFF_RG0:    w_rd_mux = DATA_W'(r_rg0);
            OFF_RG1:    w_rd_mux = DATA_W'(r_rg1);
            OFF_NUM:    w_rd_mux = r_num;
            OFF_SWITCH: w_rd_mux = DATA_W'(r_sw_s2);
            OFF_TIMER:  w_rd_mux = r_timer;
            OFF_CMP:    w_rd_mux = r_cmp;
            OFF_CTRL:   w_rd_mux = DATA_W'({r_ctrl_pend, r_ctrl_ie, r_ctrl_en});
            default:    w_rd_mux = '0;
        endcase
    end

    // Read port: 1-cycle latency, misses and unmapped offsets return 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_hit ? w_rd_mux : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_led <= '0;
            r_rg0 <= '0;
            r_rg1 <= '0;
            r_num <= '0;
            r_cmp <= '0;
        end else if (w_wr) begin
            if (w_sel_led) begin
                if (wen[0]) r_led[7:0]  <= wdata[7:0];
                if (wen[1]) r_led[15:8] <= wdata[15:8];
            end
            if (w_sel_rg0 && wen[0]) r_rg0 <= wdata[1:0];
            if (w_sel_rg1 && wen[0]) r_rg1 <= wdata[1:0];
            if (w_sel_num) r_num <= w_num_wr;
            if (w_sel_cmp) r_cmp <= w_cmp_wr;
        end
    end

    // Two-flop synchronizer for the asynchronous switches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= switch_i;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // CPU write wins over the increment; unwritten lanes keep the old value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (w_wr && w_sel_timer) begin
            r_timer <= w_timer_wr;
        end else if (r_ctrl_en) begin
            r_timer <= r_timer + DATA_W'(1);
        end
    end

    // Compare set takes priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ctrl_en   <= 1'b0;
            r_ctrl_ie   <= 1'b0;
            r_ctrl_pend <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl_en <= wdata[0];
                r_ctrl_ie <= wdata[1];
            end
            if (w_cmp_match) begin
                r_ctrl_pend <= 1'b1;
            end else if (w_pend_clr) begin
                r_ctrl_pend <= 1'b0;
            end
        end
    end

    assign rdata       = r_rdata;
    assign led_o       = r_led;
    assign led_rg0_o   = r_rg0;
    assign led_rg1_o   = r_rg1;
    assign num_o       = r_num;
    assign timer_int_o = r_ctrl_pend & r_ctrl_ie;

endmodule

// File: tb/tb_confreg_sram_slave.sv
// Bench for confreg_sram_slave: feature tasks with inline checks plus a read
// scoreboard that compares each queued expectation one cycle after the request.
module tb_confreg_sram_slave;

    localparam logic [31:0] BASE   = 32'h1faf_0000;
    localparam logic [31:0] A_LED  = BASE | 32'hF000;
    localparam logic [31:0] A_RG0  = BASE | 32'hF004;
    localparam logic [31:0] A_RG1  = BASE | 32'hF008;
    localparam logic [31:0] A_NUM  = BASE | 32'hF010;
    localparam logic [31:0] A_SW   = BASE | 32'hF020;
    localparam logic [31:0] A_TMR  = BASE | 32'hE000;
    localparam logic [31:0] A_CMP  = BASE | 32'hE004;
    localparam logic [31:0] A_CTRL = BASE | 32'hE008;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  switch_i;
    logic [15:0] led_o;
    logic [1:0]  led_rg0_o;
    logic [1:0]  led_rg1_o;
    logic [31:0] num_o;
    logic        timer_int_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    confreg_sram_slave #(.BASE_HI(16'h1faf), .SW_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata), .switch_i(switch_i), .led_o(led_o), .led_rg0_o(led_rg0_o),
        .led_rg1_o(led_rg1_o), .num_o(num_o), .timer_int_o(timer_int_o)
    );

    // Scoreboard: every read accepted at an edge is checked just after it.
    always @(posedge clk) begin
        if (rst === 1'b1 && en === 1'b1 && wen === 4'b0000) begin
            #1;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read: got %h want no read", rdata);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (rdata !== e) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", n, rdata, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        en = 1'b1; wen = be; addr = a; wdata = d;
        @(posedge clk); #1;
        en = 1'b0; wen = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        en = 1'b1; wen = 4'b0000; addr = a;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b1; wen = 4'b1111; addr = A_LED; wdata = 32'h0000_FFFF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (led_o !== 16'h0) begin bad++; $display("FAIL reset_led: got %h want 0000", led_o); end
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        total++;
        if (timer_int_o !== 1'b0) begin bad++; $display("FAIL reset_int: got %b want 0", timer_int_o); end
        total++;
        if (num_o !== 32'h0) begin bad++; $display("FAIL reset_num: got %h want 0", num_o); end
        en = 1'b0; wen = 4'b0000; rst = 1'b1;
        rd(A_LED, 32'h0, "reset_read_led");
    endtask

    task automatic test_byte_writes;
        wr(A_NUM, 32'h1122_3344, 4'b1111);
        wr(A_NUM, 32'hAABB_CCDD, 4'b0101);
        rd(A_NUM, 32'h11BB_33DD, "byte_num_read");
        total++;
        if (num_o !== 32'h11BB_33DD) begin bad++; $display("FAIL byte_num_o: got %h want 11bb33dd", num_o); end
        wr(A_LED, 32'hFFFF_FFFF, 4'b1111);
        rd(A_LED, 32'h0000_FFFF, "led_width_read");
        wr(A_LED, 32'h0000_0000, 4'b0010);
        rd(A_LED, 32'h0000_00FF, "led_lane1_read");
        wr(A_LED, 32'h0000_0000, 4'b0001);
    endtask

    task automatic test_decode;
        wr(32'h1fae_f000, 32'h0000_FFFF, 4'b1111);
        total++;
        if (led_o !== 16'h0) begin bad++; $display("FAIL miss_write_led: got %h want 0000", led_o); end
        rd(A_NUM, 32'h11BB_33DD, "num_reread");
        rd(BASE | 32'hF030, 32'h0, "unmapped_read");
        rd(A_NUM, 32'h11BB_33DD, "num_reread2");
        addr = A_LED; en = 1'b0; wen = 4'b0000;
        @(posedge clk); #1;
        total++;
        if (rdata !== 32'h11BB_33DD) begin bad++; $display("FAIL hold_en0: got %h want 11bb33dd", rdata); end
        wr(A_LED, 32'h1234_ABCD, 4'b1111);
        total++;
        if (rdata !== 32'h11BB_33DD) begin bad++; $display("FAIL hold_on_write: got %h want 11bb33dd", rdata); end
        total++;
        if (led_o !== 16'hABCD) begin bad++; $display("FAIL led_write: got %h want abcd", led_o); end
        rd(BASE | 32'hF003, 32'h0000_ABCD, "addr_low_ignored");
        wr(A_RG0, 32'h0000_00FF, 4'b0001);
        total++;
        if (led_rg0_o !== 2'b11) begin bad++; $display("FAIL rg0_out: got %b want 11", led_rg0_o); end
        rd(A_RG0, 32'h3, "rg0_read");
        rd(32'h1fae_f010, 32'h0, "miss_read");
        wr(A_RG1, 32'h0000_0202, 4'b0010);
        total++;
        if (led_rg1_o !== 2'b00) begin bad++; $display("FAIL rg1_lane: got %b want 00", led_rg1_o); end
        wr(A_RG1, 32'h0000_0002, 4'b0001);
        rd(A_RG1, 32'h2, "rg1_read");
    endtask

    task automatic test_switch;
        switch_i = 8'hA5;
        idle(1);
        rd(A_SW, 32'h0, "switch_one_edge");
        rd(A_SW, 32'hA5, "switch_two_edges");
        wr(A_SW, 32'h0, 4'b1111);
        rd(A_SW, 32'hA5, "switch_ro");
    endtask

    task automatic test_timer_irq;
        wr(A_CMP, 32'd5, 4'b1111);
        wr(A_CTRL, 32'b011, 4'b0001);
        for (int k = 1; k <= 8; k++) begin
            logic want;
            idle(1);
            want = (k >= 6);
            total++;
            if (timer_int_o !== want) begin
                bad++;
                $display("FAIL irq_cycle%0d: got %b want %b", k, timer_int_o, want);
            end
        end
        wr(A_CTRL, 32'b111, 4'b0001);
        total++;
        if (timer_int_o !== 1'b0) begin bad++; $display("FAIL pend_w1c: got %b want 0", timer_int_o); end
        rd(A_CTRL, 32'h3, "ctrl_after_clear");
        wr(A_TMR, 32'h20, 4'b1111);
        wr(A_CMP, 32'h21, 4'b1111);
        wr(A_CTRL, 32'b111, 4'b0001);
        total++;
        if (timer_int_o !== 1'b1) begin bad++; $display("FAIL set_beats_clear: got %b want 1", timer_int_o); end
        wr(A_CTRL, 32'b001, 4'b0001);
        total++;
        if (timer_int_o !== 1'b0) begin bad++; $display("FAIL ie_mask: got %b want 0", timer_int_o); end
        rd(A_CTRL, 32'h5, "pend_kept_when_masked");
        wr(A_CTRL, 32'b011, 4'b0001);
        total++;
        if (timer_int_o !== 1'b1) begin bad++; $display("FAIL ie_unmask: got %b want 1", timer_int_o); end
    endtask

    task automatic test_timer_wrap;
        wr(A_TMR, 32'hFFFF_FFFF, 4'b1111);
        idle(1);
        rd(A_TMR, 32'h0, "timer_wrap");
        wr(A_TMR, 32'h100, 4'b1111);
        rd(A_TMR, 32'h100, "timer_override");
        rd(A_TMR, 32'h101, "timer_count");
        wr(A_CTRL, 32'b000, 4'b0001);
        idle(3);
        rd(A_TMR, 32'h103, "timer_frozen");
        wr(A_CTRL, 32'b001, 4'b0001);
        wr(A_TMR, 32'h0000_00AA, 4'b0001);
        rd(A_TMR, 32'h1AA, "timer_lane_write");
        wr(A_CTRL, 32'b000, 4'b0001);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; wen = 4'b0000; addr = 32'h0; wdata = 32'h0; switch_i = 8'h00;
        test_reset();
        test_byte_writes();
        test_decode();
        test_switch();
        test_timer_irq();
        test_timer_wrap();
        idle(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_reads: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/confreg_sram_slave.md
Name: confreg_sram_slave

Overview:
- Memory-mapped configuration/peripheral register block on the data SRAM port.
- It is the responder for the CPU datapath's data SRAM requests (enable, 4-bit byte write enable, physical address, write data) and returns read data.
- It holds the LEDs, RG LEDs, the numeric display value, the synchronized switches and a compare timer with an interrupt output. The interrupt feeds one bit of the CPU's ext_int.

Parameters:
- BASE_HI, 16'h1faf, required value of addr[31:16] for a hit.
- SW_W, 8, switch input width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  access request valid this cycle.
- wen  in  4  byte write enables; 0000 = read.
- addr  in  32  physical byte address (already translated by the CPU).
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- switch_i  in  SW_W  raw asynchronous switches.
- led_o  out  16  LED register.
- led_rg0_o  out  2  RG LED 0.
- led_rg1_o  out  2  RG LED 1.
- num_o  out  32  7-segment display value.
- timer_int_o  out  1  timer interrupt, level.

Behaviour:
- Reset: sampled when rst==0 at a clk edge. All registers go to 0: rdata, led_o, led_rg0_o, led_rg1_o, num_o, TIMER, CMP, CTRL, and both switch sync stages. timer_int_o is 0.
- A reset asserted mid-access drops that access; no write takes effect.

Decode:
- hit = en & (addr[31:16]==BASE_HI). The register is selected by addr[15:0]; addr[1:0] is ignored.
- Map:
  - 0xF000 LED: RW, bits[15:0].
  - 0xF004 RG0: RW, bits[1:0].
  - 0xF008 RG1: RW, bits[1:0].
  - 0xF010 NUM: RW, 32 bits.
  - 0xF020 SWITCH: RO, bits[SW_W-1:0].
  - 0xE000 TIMER: RW.
  - 0xE004 CMP: RW.
  - 0xE008 CTRL: bit0 EN, bit1 IE, bit2 PEND (write-1-to-clear).
- Unimplemented bits read 0.

Writes:
- Take effect at the clk edge when hit & wen!=0.
- Byte lane i is updated only if wen[i]; other lanes keep their value.
- Bits beyond a register's width are discarded.
- Misses, RO targets and unmapped offsets are ignored and cause no error.

Reads:
- When hit & wen==0, rdata <= selected register value at the edge, so data is valid the cycle after the request (1-cycle latency).
- An unmapped offset or a miss with en=1 & wen==0 loads rdata with 0.
- When en==0 or wen!=0, rdata holds its previous value.
- A read of TIMER returns the value before that cycle's increment.

Switch sync:
- Two flops; SWITCH reads the second stage.
- Latency from switch_i to a readable value is 2 edges.

Timer:
- If EN=1, TIMER <= TIMER+1 each cycle, wrapping 0xFFFFFFFF -> 0.
- A CPU write to TIMER in the same cycle wins over the increment, and the written lanes take the write data. Unwritten lanes take the old value; they are not incremented.
- Compare: if EN=1 and TIMER==CMP (pre-increment value), PEND <= 1.
- If a set and a W1C of PEND happen in the same cycle, the set wins.
- Writing 0 to bit2 leaves PEND unchanged.
- Writing EN=0 freezes TIMER; no compares occur while EN=0.
- timer_int_o = PEND & IE (combinational from registers).
- Clearing IE masks the output without clearing PEND.

Simultaneous events: only one access per cycle exists. A back-to-back write then read of the same register returns the new value (the write happened at the prior edge).

Test Plan:
- Reset: hold rst=0 for 3 cycles with en=1, wen=1111, addr 0x1faff000, wdata 0xFFFF -> led_o=0, rdata=0, timer_int_o=0. Release rst and read 0xF000 -> rdata=0 one cycle later.
- Byte writes: write NUM=0x11223344 with wen=1111, then wdata 0xAABBCCDD with wen=0101 -> read yields 0x11BB33DD; num_o matches.
- Decode: write 0x1fae_f000 (miss) with 0xFFFF -> led_o unchanged at 0. Read 0x1faf_f030 -> rdata=0. Read with en=0 -> rdata holds its previous value.
- Switch: switch_i=0xA5 at edge N -> SWITCH readable as 0xA5 for a read issued at edge N+2; a write to 0xF020 has no effect.
- Timer interrupt: CMP=5, CTRL=0b011 written while TIMER=0 -> PEND set at the edge where TIMER==5, timer_int_o=1 the following cycle. Write CTRL=0b111 -> PEND clears and timer_int_o=0, unless TIMER==CMP in that cycle, in which case it stays 1.
- Timer wrap/override: set TIMER=0xFFFFFFFF with EN=1 -> the next read shows 0x00000000. A write of TIMER=0x100 while EN=1 -> the following read returns 0x100, not 0x101.
